alarm_beeper: RTL and testbench

ALARM_BEEPER -- requirements
Module: alarm_beeper

---
 rtl/alarm_pkg.sv | 33 +++
 rtl/alarm_tmr.sv | 34 +++
 rtl/alarm_beeper.sv | 171 +++++++++++++++++
 tb/tb_alarm_beeper.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding, default timing constants and width helpers for the alarm beeper.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BEEP_ON  = 3'd1,
    ST_BEEP_OFF = 3'd2,
    ST_SILENCE  = 3'd3,
    ST_SNOOZE   = 3'd4
  } alarm_state_e;

  localparam int DEF_TICK_HZ    = 100;
  localparam int DEF_BEEP_ON_T  = 10;
  localparam int DEF_BEEP_OFF_T = 10;
  localparam int DEF_BEEPS      = 3;
  localparam int DEF_SILENCE_T  = 100;
  localparam int DEF_TIMEOUT_S  = 60;
  localparam int DEF_SNOOZE_S   = 300;

  // Bits needed to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    return max2(max2(a, b), c);
  endfunction

endpackage

// File: rtl/alarm_tmr.sv
// Saturating down-counter: load wins over decrement, done while the count is zero.
module alarm_tmr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alarm_beeper.sv
// Alarm buzzer sequencer: beep bursts with silence gaps, snooze and auto-stop timeout.
//
// state       | meaning
// ST_IDLE     | armed or disarmed, waiting for alarm_match
// ST_BEEP_ON  | buzzer driven for BEEP_ON_T ticks
// ST_BEEP_OFF | gap after a beep, BEEP_OFF_T ticks
// ST_SILENCE  | pause after a full burst, SILENCE_T ticks
// ST_SNOOZE   | user snoozed, waiting SNOOZE_S seconds
module alarm_beeper
  import alarm_pkg::*;
#(
  parameter int TICK_HZ    = DEF_TICK_HZ,
  parameter int BEEP_ON_T  = DEF_BEEP_ON_T,
  parameter int BEEP_OFF_T = DEF_BEEP_OFF_T,
  parameter int BEEPS      = DEF_BEEPS,
  parameter int SILENCE_T  = DEF_SILENCE_T,
  parameter int TIMEOUT_S  = DEF_TIMEOUT_S,
  parameter int SNOOZE_S   = DEF_SNOOZE_S
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic alarm_en,
  input  logic alarm_match,
  input  logic stop,
  input  logic snooze,
  output logic buzzer,
  output logic ringing,
  output logic snoozing
);

  localparam int PH_W      = cnt_width(max3(BEEP_ON_T, BEEP_OFF_T, SILENCE_T) - 1);
  localparam int TMO_TICKS = TIMEOUT_S * TICK_HZ;
  localparam int SNZ_TICKS = SNOOZE_S * TICK_HZ;
  // Timeout and snooze share one counter measured in raw ticks.
  localparam int LG_W      = cnt_width(max2(TMO_TICKS, SNZ_TICKS) - 1);
  localparam int IDX_W     = cnt_width(BEEPS);

  localparam logic [PH_W-1:0]  ON_LD    = PH_W'(BEEP_ON_T - 1);
  localparam logic [PH_W-1:0]  OFF_LD   = PH_W'(BEEP_OFF_T - 1);
  localparam logic [PH_W-1:0]  SIL_LD   = PH_W'(SILENCE_T - 1);
  localparam logic [LG_W-1:0]  TMO_LD   = LG_W'(TMO_TICKS - 1);
  localparam logic [LG_W-1:0]  SNZ_LD   = LG_W'(SNZ_TICKS - 1);
  localparam logic [IDX_W-1:0] BEEPS_L  = IDX_W'(BEEPS);

  alarm_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ph_load, ph_done, ph_exp;
  logic [PH_W-1:0]  ph_val;
  logic             lg_load, lg_done, lg_exp;
  logic [LG_W-1:0]  lg_val;
  logic             is_ringing;
  logic             buzzer_q, ringing_q, snoozing_q;

  alarm_tmr #(.W(PH_W)) u_phase_tmr (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .dec_i      (tick),
    .done_o     (ph_done)
  );

  alarm_tmr #(.W(LG_W)) u_long_tmr (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (lg_load),
    .load_val_i (lg_val),
    .dec_i      (tick),
    .done_o     (lg_done)
  );

  assign ph_exp     = tick & ph_done;
  assign lg_exp     = tick & lg_done;
  assign is_ringing = (state_q == ST_BEEP_ON) || (state_q == ST_BEEP_OFF) ||
                      (state_q == ST_SILENCE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ph_load = 1'b0;
    ph_val  = ON_LD;
    lg_load = 1'b0;
    lg_val  = TMO_LD;

    if (!alarm_en || stop) begin
      state_d = ST_IDLE;
    end else if (snooze && is_ringing) begin
      state_d = ST_SNOOZE;
      lg_load = 1'b1;
      lg_val  = SNZ_LD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarm_match) begin
            state_d = ST_BEEP_ON;
            idx_d   = '0;
            ph_load = 1'b1;
            lg_load = 1'b1;
          end
        end
        ST_BEEP_ON: begin
          if (lg_exp) begin
            state_d = ST_IDLE;
          end else if (ph_exp) begin
            state_d = ST_BEEP_OFF;
            idx_d   = idx_q + IDX_W'(1);
            ph_load = 1'b1;
            ph_val  = OFF_LD;
          end
        end
        ST_BEEP_OFF: begin
          if (lg_exp) begin
            state_d = ST_IDLE;
          end else if (ph_exp) begin
            ph_load = 1'b1;
            if (idx_q < BEEPS_L) begin
              state_d = ST_BEEP_ON;
            end else begin
              state_d = ST_SILENCE;
              ph_val  = SIL_LD;
            end
          end
        end
        ST_SILENCE: begin
          if (lg_exp) begin
            state_d = ST_IDLE;
          end else if (ph_exp) begin
            state_d = ST_BEEP_ON;
            idx_d   = '0;
            ph_load = 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (lg_exp) begin
            state_d = ST_BEEP_ON;
            idx_d   = '0;
            ph_load = 1'b1;
            lg_load = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the next state so they line up with state_q and never see inputs directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buzzer_q   <= (state_d == ST_BEEP_ON);
      ringing_q  <= (state_d == ST_BEEP_ON) || (state_d == ST_BEEP_OFF) ||
                    (state_d == ST_SILENCE);
      snoozing_q <= (state_d == ST_SNOOZE);
    end
  end

  assign buzzer   = buzzer_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_beeper.sv
// Scoreboard bench: expected output changes (tick stamp + buzzer/ringing/snoozing) are queued by stimulus.
`timescale 1ns/1ps
module tb_alarm_beeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic alarm_en = 1'b0;
  logic alarm_match = 1'b0;
  logic stop = 1'b0;
  logic snooze = 1'b0;
  logic buzzer, ringing, snoozing;

  typedef struct {
    int   t;
    logic [2:0] o;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         tick_cnt = 0;
  int         tick_per = 1;
  bit         mon_en = 1'b0;
  logic [2:0] prev = 3'b000;

  alarm_beeper dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .alarm_en    (alarm_en),
    .alarm_match (alarm_match),
    .stop        (stop),
    .snooze      (snooze),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tick) tick_cnt <= tick_cnt + 1;

  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      if (div >= tick_per - 1) begin
        div = 0;
        tick = 1'b1;
      end else begin
        div++;
        tick = 1'b0;
      end
    end
  end

  // Monitor: every change of the output triple must match the head of the queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en && ({buzzer, ringing, snoozing} !== prev)) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change tick=%0d got b/r/s=%b required=%b (no change)",
                   tick_cnt, {buzzer, ringing, snoozing}, prev);
        end else begin
          e = exp_q.pop_front();
          if ((e.t != tick_cnt) || ({buzzer, ringing, snoozing} !== e.o)) begin
            bad++;
            $display("FAIL event got tick=%0d b/r/s=%b required tick=%0d b/r/s=%b",
                     tick_cnt, {buzzer, ringing, snoozing}, e.t, e.o);
          end
        end
      end
      prev = {buzzer, ringing, snoozing};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic int next_t();
    return tick_cnt + (tick ? 1 : 0);
  endfunction

  task automatic push(input int t, input logic [2:0] o);
    ev_t e;
    e.t = t;
    e.o = o;
    exp_q.push_back(e);
  endtask

  // Unattended ring from base: 3 beeps of 10/10 then 100 silence, period 160, timeout at +6000.
  task automatic push_ring(input int base);
    for (int k = 0; k < 38; k++) begin
      for (int j = 0; j < 6; j++) begin
        if (160 * k + 10 * j < 6000)
          push(base + 160 * k + 10 * j, (j % 2 == 0) ? 3'b110 : 3'b010);
      end
    end
    push(base + 6000, 3'b000);
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got b/r/s=%b required=%b", name, got, req);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s got pending=%0d required=0 after %0d cycles", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic wait_until(input string name, input int target, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (next_t() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (next_t() < target) begin
      bad++;
      $display("FAIL %s got tick=%0d required=%0d", name, next_t(), target);
    end
  endtask

  task automatic pulse_match();
    alarm_match = 1'b1;
    @(negedge clk);
    alarm_match = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
  endtask

  initial begin
    int t0, ts, te;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {buzzer, ringing, snoozing}, 3'b000);
    rst = 1'b1;
    alarm_en = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // IDLE ignores snooze; a disarmed alarm ignores alarm_match
    pulse_snooze();
    alarm_en = 1'b0;
    pulse_match();
    repeat (5) @(negedge clk);
    chk("disarmed_match_idle", {buzzer, ringing, snoozing}, 3'b000);
    alarm_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_latched_match", {buzzer, ringing, snoozing}, 3'b000);

    // Unattended ring with a sparse tick; a second alarm_match in SILENCE is ignored
    tick_per = 3;
    repeat (6) @(negedge clk);
    t0 = next_t();
    push_ring(t0);
    pulse_match();
    wait_until("reach_silence", t0 + 70, 1000);
    chk("silence_outputs", {buzzer, ringing, snoozing}, 3'b010);
    pulse_match();
    wait_drain("timeout_drain", 19000);
    repeat (300) @(negedge clk);
    chk("idle_after_timeout", {buzzer, ringing, snoozing}, 3'b000);

    // Snooze at tick 25, 30000 ticks of snooze, then a fresh 6000-tick ring
    tick_per = 1;
    repeat (4) @(negedge clk);
    t0 = next_t();
    push(t0, 3'b110);
    push(t0 + 10, 3'b010);
    push(t0 + 20, 3'b110);
    pulse_match();
    wait_until("reach_tick25", t0 + 25, 100);
    ts = next_t();
    push(ts, 3'b001);
    push_ring(ts + 30000);
    pulse_snooze();
    wait_until("mid_snooze", ts + 15000, 16000);
    chk("mid_snooze_outputs", {buzzer, ringing, snoozing}, 3'b001);
    pulse_snooze();
    pulse_match();
    wait_drain("snooze_ring_drain", 22000);

    // stop and snooze together: stop wins
    repeat (4) @(negedge clk);
    t0 = next_t();
    push(t0, 3'b110);
    push(t0 + 10, 3'b010);
    pulse_match();
    wait_until("reach_off", t0 + 15, 100);
    push(next_t(), 3'b000);
    stop = 1'b1;
    snooze = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    snooze = 1'b0;
    wait_drain("stop_drain", 20);
    repeat (20) @(negedge clk);
    chk("stop_snooze_idle", {buzzer, ringing, snoozing}, 3'b000);

    // Asynchronous reset in BEEP_ON, then no re-arm without a new alarm_match
    t0 = next_t();
    push(t0, 3'b110);
    pulse_match();
    wait_drain("beep_on_drain", 20);
    wait_until("reach_beep4", t0 + 4, 100);
    chk("beep_on_before_reset", {buzzer, ringing, snoozing}, 3'b110);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {buzzer, ringing, snoozing}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    repeat (60) @(negedge clk);
    chk("idle_after_reset_release", {buzzer, ringing, snoozing}, 3'b000);

    // Disarming while snoozing returns to IDLE on the next edge
    t0 = next_t();
    push(t0, 3'b110);
    pulse_match();
    wait_until("reach_beep5", t0 + 5, 100);
    ts = next_t();
    push(ts, 3'b001);
    pulse_snooze();
    wait_drain("snooze_entry_drain", 20);
    repeat (10) @(negedge clk);
    te = next_t();
    push(te, 3'b000);
    alarm_en = 1'b0;
    @(negedge clk);
    wait_drain("disarm_drain", 10);
    alarm_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_disarm", {buzzer, ringing, snoozing}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
